inst_sequencer: RTL
===================

Name: inst_sequencer

Overview:
- Upstream feeder for the 8-bit CPU core. It stores a short program of instruction pairs and replays them one pair per cycle.
- Each pair is an opcode/R1 byte, which drives the core's ui_in, and an operand byte (R2/R3 or load data), which drives the core's uio_in.
- Programs are loaded through a valid/ready port, then issued on a run command, with hold and clear controls.
- Between programs the block drives a NOP (opcode 4'b0100). It never drives 8'h00, which would decode as MVR and corrupt a register.

Parameters:
DEPTH, 8, number of instruction-pair entries (power of two).
ADDR_W, 3, log2(DEPTH).
NOP_INST, 8'h40, idle opcode byte driven when not issuing.

Ports:
clk  in  1  clock, all state changes on rising edge.
rst_n  in  1  reset, synchronous, active-low.
load_valid  in  1  load request.
load_ready  out  1  load accepted this cycle when high together with load_valid.
load_inst  in  8  opcode byte to store.
load_operand  in  8  operand byte to store.
run  in  1  start/replay program (level sampled each cycle).
hold  in  1  freeze issue while in RUN.
clear  in  1  empty the program.
cpu_inst  out  8  registered, to core ui_in.
cpu_operand  out  8  registered, to core uio_in.
issue_valid  out  1  registered, high when cpu_inst/cpu_operand hold a real program entry.
count  out  ADDR_W+1  entries stored (0..DEPTH).
busy  out  1  state==RUN.
done  out  1  state==DONE.
ovf  out  1  sticky; set on load_valid while full or outside IDLE.

Behaviour:
- Reset: applied on a clk edge with rst_n==0, from any state including mid-RUN. Resulting values:
  - state=IDLE; wr_ptr=rd_ptr=issued=0; count=0.
  - cpu_inst=NOP_INST; cpu_operand=8'h00; issue_valid=0; ovf=0.
  - Memory contents need no reset; count=0 makes them invalid.
- States: IDLE, RUN, DONE.
- load_ready = (state==IDLE) & (count<DEPTH) & !run & !clear. It is combinational.
- IDLE:
  - clear has priority and sets count=0, wr_ptr=0.
  - Else run with count>0 sets rd_ptr=0, issued=0 and moves to RUN.
  - Else a load handshake writes mem[wr_ptr]={load_inst,load_operand}, increments wr_ptr (wraps at DEPTH) and increments count.
  - run with count==0 is ignored and the block stays in IDLE.
- RUN, one entry per cycle:
  - If !hold: cpu_inst/cpu_operand <= mem[rd_ptr], issue_valid<=1, rd_ptr++, issued++.
  - If hold: cpu_inst<=NOP_INST, cpu_operand<=0, issue_valid<=0; rd_ptr and issued are frozen.
  - When issued==count, the next edge goes to DONE and drives NOP with issue_valid=0. Exactly count entries are ever issued.
- Latency: run sampled at edge N puts entry 0 on the outputs after edge N+1. Entry k appears after edge N+1+k plus the number of hold cycles.
- Core-side timing: the core consumes each pair at the following edge, so an entry's effect on core state is visible 2 edges after its issue edge.
- clear in RUN aborts:
  - Next edge: IDLE, count=0, outputs NOP, issue_valid=0.
  - clear has priority over hold.
- DONE: done=1.
  - run replays: moves to RUN with rd_ptr=0, issued=0, and count is unchanged.
  - clear moves to IDLE and empties.
  - If both are high, clear wins.
- ovf: set when load_valid is high and load_ready is low for any reason other than run/clear in IDLE (i.e. full, RUN, or DONE). It is cleared only by reset. Rejected data is discarded.
- DEPTH entries: count reaches DEPTH and the run issues all DEPTH entries; rd_ptr wraps to 0 without effect.

Decomposition:
- Shared package:
  - Opcode constants: NOP_INST, plus the MVR/LDB/STB/RDS/ALU opcodes already used by the core.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One natural sub-module: prog_mem. It is a DEPTH x 16 register array with a single write port and a combinational read port. Only the controller FSM lives in inst_sequencer.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 edges → cpu_inst=8'h40, cpu_operand=0, issue_valid=0, count=0, load_ready=1.
- Load and run: load {8'h11,8'h05}, {8'h12,8'h07}, {8'hB1,8'h12}, {8'h21,8'h00}, then pulse run. Required response:
  - The four pairs appear on consecutive cycles starting one edge after run, with issue_valid=1 for exactly 4 cycles, then done=1.
  - Through the core, this is LDB R1=5, LDB R2=7, ADD R1=R1+R2, STB R1, and uo_out=8'h0C.
- Hold: hold=1 for 3 cycles after entry 1 → NOP and issue_valid=0 for those 3 cycles. Entry 2 follows immediately after, and no entry is skipped or repeated.
- Full/overflow: load 8 entries → load_ready=0, count=8. A 9th load_valid sets ovf=1 and leaves count=8. The run issues exactly 8 entries.
- Clear mid-run and replay: clear on the 2nd issue cycle → next edge IDLE, count=0, cpu_inst=8'h40. Separately, run in DONE replays the identical sequence.
- Reset mid-RUN: rst_n=0 for one edge during issue → outputs NOP, count=0, ovf=0, state IDLE. A run with count==0 afterwards produces no issue.

Source files
------------

// File: rtl/inst_sequencer_pkg.sv
// Shared constants, core opcodes and controller state encoding for the
// instruction sequencer that feeds the 8-bit CPU core.
package inst_sequencer_pkg;

   localparam int DEF_DEPTH  = 8;
   localparam int DEF_ADDR_W = 3;

   // Upper-nibble opcodes understood by the core
   localparam logic [3:0] OP_MVR = 4'h0;
   localparam logic [3:0] OP_LDB = 4'h1;
   localparam logic [3:0] OP_STB = 4'h2;
   localparam logic [3:0] OP_RDS = 4'h3;
   localparam logic [3:0] OP_NOP = 4'h4;
   localparam logic [3:0] OP_ALU = 4'hB;

   // Idle byte: a real NOP, never 8'h00 (that decodes as MVR)
   localparam logic [7:0] DEF_NOP_INST = {OP_NOP, 4'h0};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   // Memory word layout: opcode byte in the upper half, operand below
   function automatic logic [15:0] pack_pair(input logic [7:0] inst,
                                             input logic [7:0] operand);
      return {inst, operand};
   endfunction

endpackage

// File: rtl/inst_sequencer_prog_mem.sv
// Program store: DEPTH x 16 register array, one write port, combinational read.
// Contents are not reset; the controller's entry count decides validity.
module inst_sequencer_prog_mem
   import inst_sequencer_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [15:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [15:0]       rdata_o
);

   logic [15:0] mem_q [DEPTH];

   // Write the addressed entry on an accepted load
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: loads a short program of opcode/operand pairs and
// replays it to the CPU core one pair per cycle, driving NOP otherwise.
//
// Load handshake: a pair is accepted on a rising edge where load_valid and
// load_ready are both high; load_ready depends only on state, fill level,
// run and clear, never on load_valid. A load_valid that meets load_ready low
// because the store is full or the sequencer is not idle is dropped and
// flags ovf (sticky until reset).
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter int         DEPTH    = DEF_DEPTH,
   parameter int         ADDR_W   = DEF_ADDR_W,
   parameter logic [7:0] NOP_INST = DEF_NOP_INST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [7:0]        load_inst,
   input  logic [7:0]        load_operand,
   input  logic              run,
   input  logic              hold,
   input  logic              clear,
   output logic [7:0]        cpu_inst,
   output logic [7:0]        cpu_operand,
   output logic              issue_valid,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output seq_state_e        dbg_state
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   seq_state_e        state_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   issued_q;
   logic [7:0]        cpu_inst_q;
   logic [7:0]        cpu_operand_q;
   logic              issue_valid_q;
   logic              ovf_q;
   logic              ovf_d;
   logic              load_fire;
   logic [15:0]       rd_pair;

   assign load_ready = (state_q == ST_IDLE) && (count_q < FULL_CNT) && !run && !clear;
   assign load_fire  = load_valid && load_ready;

   inst_sequencer_prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk     (clk),
      .we_i    (load_fire),
      .waddr_i (wr_ptr_q),
      .wdata_i (pack_pair(load_inst, load_operand)),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_pair)
   );

   // Overflow flag: a refused load that is not just a run/clear collision in IDLE
   always_comb begin
      ovf_d = ovf_q;
      if (load_valid && ((state_q != ST_IDLE) || (count_q == FULL_CNT))) begin
         ovf_d = 1'b1;
      end
   end

   // Controller FSM with registered issue outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         issued_q      <= '0;
         cpu_inst_q    <= NOP_INST;
         cpu_operand_q <= 8'h00;
         issue_valid_q <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         ovf_q         <= ovf_d;
         // NOP unless an entry is issued below
         cpu_inst_q    <= NOP_INST;
         cpu_operand_q <= 8'h00;
         issue_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (clear) begin
                  count_q  <= '0;
                  wr_ptr_q <= '0;
               end else if (run && (count_q != '0)) begin
                  rd_ptr_q <= '0;
                  issued_q <= '0;
                  state_q  <= ST_RUN;
               end else if (load_fire) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  count_q  <= count_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (clear) begin
                  count_q  <= '0;
                  wr_ptr_q <= '0;
                  state_q  <= ST_IDLE;
               end else if (issued_q == count_q) begin
                  state_q <= ST_DONE;
               end else if (!hold) begin
                  cpu_inst_q    <= rd_pair[15:8];
                  cpu_operand_q <= rd_pair[7:0];
                  issue_valid_q <= 1'b1;
                  rd_ptr_q      <= rd_ptr_q + 1'b1;
                  issued_q      <= issued_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (clear) begin
                  count_q  <= '0;
                  wr_ptr_q <= '0;
                  state_q  <= ST_IDLE;
               end else if (run) begin
                  rd_ptr_q <= '0;
                  issued_q <= '0;
                  state_q  <= ST_RUN;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_inst    = cpu_inst_q;
   assign cpu_operand = cpu_operand_q;
   assign issue_valid = issue_valid_q;
   assign count       = count_q;
   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign ovf         = ovf_q;
   assign dbg_state   = state_q;

endmodule
